// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
//
// Memory-side responder for the CPU data SRAM interface. It accepts the
// en/wen/addr/wdata request driven by the execute stage each cycle. Writes
// update only the enabled bytes of the addressed word. Reads return data
// after READ_LAT cycles, with a one-cycle valid strobe for the memory stage.
// This is the data-memory model shared by the core testbench and the FPGA top.
//
// Parameters:
//   ADDR_W    word-index width; the array holds 2^ADDR_W 32-bit words
//   READ_LAT  read latency in cycles, 1..4
//
// Ports:
//   clk               system clock, all state updates on the rising edge
//   reset             synchronous, active-high reset
//   data_sram_en      request enable (0 = idle, wen/addr/wdata ignored)
//   data_sram_wen     byte write enables, bit i -> wdata[8i+7:8i]; 0 = read
//   data_sram_addr    byte address; word index is addr[ADDR_W+1:2]
//   data_sram_wdata   write data, little-endian byte lanes
//   data_sram_rdata   read data, held until the next read completes
//   data_sram_rvalid  one-cycle pulse when a read completes
//   rd_pending        high while a read is still travelling the pipeline
// ---------------------------------------------------------------------------
module data_sram_responder #(
  parameter int ADDR_W   = 14,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        rd_pending
);

  localparam int DEPTH = 1 << ADDR_W;

  // Reject unsupported configurations at elaboration time.
  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
    $error("data_sram_responder: READ_LAT must be in 1..4");
  end
  if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
    $error("data_sram_responder: ADDR_W must be in 1..29");
  end

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic              is_write;
  logic              is_read;

  // The address bits outside the word index are ignored on purpose. Dropping
  // the low bits means there is no alignment check. Dropping the high bits
  // makes addresses alias. Both are gathered here so they are visibly unused.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  assign word_idx = data_sram_addr[ADDR_W+1:2];

  // A request that arrives in a reset cycle is dropped entirely.
  assign is_write = !reset && data_sram_en && (data_sram_wen != 4'b0000);
  assign is_read  = !reset && data_sram_en && (data_sram_wen == 4'b0000);

  // Byte-masked write. Reset never clears the array, so this block has no
  // reset branch.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (is_write && data_sram_wen[i]) begin
        mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  if (READ_LAT == 1) begin : g_lat1
    // The completion lands on the issue edge itself. The sampled word is
    // held in mem_q until the next read. have_data forces rdata to zero
    // between reset and the first completed read.
    logic [31:0] mem_q;
    logic        have_data;
    logic        rvalid_q;

    always_ff @(posedge clk) begin
      if (is_read) begin
        mem_q <= mem[word_idx];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        have_data <= 1'b0;
        rvalid_q  <= 1'b0;
      end else begin
        rvalid_q <= is_read;
        if (is_read) begin
          have_data <= 1'b1;
        end
      end
    end

    assign data_sram_rdata  = have_data ? mem_q : 32'h0000_0000;
    assign data_sram_rvalid = rvalid_q;
    assign rd_pending       = 1'b0;
  end else begin : g_latn
    // Stage 0 samples the array at the issue edge. Each later stage shifts
    // one step per cycle. The output register takes the last stage, so a
    // read issued at edge T completes at edge T+READ_LAT-1. In-flight data
    // is never re-read, so a later write cannot disturb it.
    localparam int STAGES = READ_LAT - 1;

    logic [STAGES-1:0] stage_valid;
    logic [31:0]       stage_data [STAGES];
    logic [31:0]       rdata_q;
    logic              rvalid_q;

    // The data path carries no reset; only the valid bits need clearing.
    always_ff @(posedge clk) begin
      if (is_read) begin
        stage_data[0] <= mem[word_idx];
      end
      for (int k = 1; k < STAGES; k++) begin
        stage_data[k] <= stage_data[k-1];
      end
    end

    // Clearing the valid bits on reset discards every in-flight read.
    always_ff @(posedge clk) begin
      if (reset) begin
        stage_valid <= '0;
        rvalid_q    <= 1'b0;
        rdata_q     <= 32'h0000_0000;
      end else begin
        stage_valid[0] <= is_read;
        for (int k = 1; k < STAGES; k++) begin
          stage_valid[k] <= stage_valid[k-1];
        end
        rvalid_q <= stage_valid[STAGES-1];
        if (stage_valid[STAGES-1]) begin
          rdata_q <= stage_data[STAGES-1];
        end
      end
    end

    assign data_sram_rdata  = rdata_q;
    assign data_sram_rvalid = rvalid_q;
    assign rd_pending       = |stage_valid;
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_data_sram_responder
//
// Drives three responders (READ_LAT = 1, 2, 3) from one shared request
// stream. The reference model keeps the memory as words indexed by word
// address. It keeps reads as a table keyed by issue cycle. Each cycle it
// derives which read completes for each latency, the held rdata value, and
// whether any read is still in flight.
// ---------------------------------------------------------------------------
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata  [3];
  logic        rvalid [3];
  logic        pend   [3];

  int lat [3] = '{1, 2, 3};

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_reset = -1000;

  logic [31:0] mem_model [int];
  logic [31:0] read_at   [int];
  logic [31:0] exp_rdata [3];

  data_sram_responder #(.ADDR_W(14), .READ_LAT(1)) dut_lat1 (
    .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata[0]), .data_sram_rvalid(rvalid[0]), .rd_pending(pend[0])
  );

  data_sram_responder #(.ADDR_W(14), .READ_LAT(2)) dut_lat2 (
    .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata[1]), .data_sram_rvalid(rvalid[1]), .rd_pending(pend[1])
  );

  data_sram_responder #(.ADDR_W(14), .READ_LAT(3)) dut_lat3 (
    .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata[2]), .data_sram_rvalid(rvalid[2]), .rd_pending(pend[2])
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d, required completion", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h (cycle %0d)",
               tag, observed, expected, cycle);
    end
  endtask

  // Applies what happened at the edge just taken to the model.
  task automatic updateModel(input logic r, input logic e, input logic [3:0] w,
                             input logic [31:0] a, input logic [31:0] d);
    int idx;
    logic [31:0] word;
    cycle++;
    idx = int'(a[15:2]);
    if (r) begin
      last_reset = cycle;
      for (int l = 0; l < 3; l++) exp_rdata[l] = 32'h0;
    end else if (e && w != 4'b0000) begin
      word = mem_model.exists(idx) ? mem_model[idx] : 32'h0;
      for (int i = 0; i < 4; i++) begin
        if (w[i]) word[8*i +: 8] = d[8*i +: 8];
      end
      mem_model[idx] = word;
    end else if (e) begin
      if (mem_model.exists(idx)) read_at[cycle] = mem_model[idx];
      else $display("[TB] bench read of unwritten word %0d ignored", idx);
    end
  endtask

  // Compares every responder against the model for the current cycle.
  task automatic checkAll();
    int k;
    logic done;
    logic busy;
    for (int l = 0; l < 3; l++) begin
      k = cycle - lat[l] + 1;
      done = (k > last_reset) && read_at.exists(k);
      if (done) exp_rdata[l] = read_at[k];
      busy = 1'b0;
      for (int j = k + 1; j <= cycle; j++) begin
        if (j > last_reset && read_at.exists(j)) busy = 1'b1;
      end
      checkOutput($sformatf("L%0d.rvalid", lat[l]), {31'b0, rvalid[l]}, {31'b0, done});
      checkOutput($sformatf("L%0d.rdata", lat[l]), rdata[l], exp_rdata[l]);
      checkOutput($sformatf("L%0d.rd_pending", lat[l]), {31'b0, pend[l]}, {31'b0, busy});
    end
  endtask

  // Drives one request, steps one edge, updates the model, then checks
  // just after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] w,
                               input logic [31:0] a, input logic [31:0] d);
    reset = r;
    en    = e;
    wen   = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    updateModel(r, e, w, a, d);
    #1;
    checkAll();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    applyStimulus(1'b0, 1'b1, w, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    applyStimulus(1'b0, 1'b1, 4'b0000, a, $urandom);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 4'($urandom), $urandom, $urandom);
  endtask

  initial begin
    int p;
    int idx;
    int op;
    logic [31:0] a;

    applyStimulus(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 4'b1111, 32'h100, 32'h1234_5678);
    checkOutput("reset.rdata", rdata[2], 32'h0);

    // Full write, then a read with one-cycle latency that stays held.
    wr(32'h100, 32'hDEAD_BEEF, 4'b1111);
    rd(32'h100);
    checkOutput("t1.rvalid", {31'b0, rvalid[0]}, 32'h1);
    checkOutput("t1.rdata", rdata[0], 32'hDEAD_BEEF);
    idle();
    checkOutput("t1.pulse", {31'b0, rvalid[0]}, 32'h0);
    idle();
    idle();
    checkOutput("t1.hold", rdata[0], 32'hDEAD_BEEF);

    // Byte lanes.
    wr(32'h40, 32'h1122_3344, 4'b1111);
    wr(32'h40, 32'h0000_AA00, 4'b0010);
    wr(32'h40, 32'hBB00_0000, 4'b1000);
    rd(32'h40);
    checkOutput("t2.lanes", rdata[0], 32'hBB22_AA44);
    idle();
    idle();

    // Back-to-back reads through the three-cycle responder.
    for (int i = 0; i < 4; i++) wr(32'(4 * i), 32'(i + 1), 4'b1111);
    for (int s = 0; s < 7; s++) begin
      if (s < 4) rd(32'(4 * s));
      else idle();
      checkOutput("t3.rvalid", {31'b0, rvalid[2]}, {31'b0, (s >= 2 && s <= 5)});
      checkOutput("t3.pend", {31'b0, pend[2]}, {31'b0, (s <= 4)});
      if (s >= 2 && s <= 5) checkOutput("t3.rdata", rdata[2], 32'(s - 1));
    end

    // A disabled request must not write; addresses alias.
    applyStimulus(1'b0, 1'b0, 4'b1111, 32'h40, 32'hFFFF_FFFF);
    rd(32'h40);
    checkOutput("t4.gated", rdata[0], 32'hBB22_AA44);
    wr(32'h0, 32'h5A5A_5A5A, 4'b1111);
    rd(32'h0001_0000);
    checkOutput("t4.alias_hi", rdata[0], 32'h5A5A_5A5A);
    rd(32'h3);
    checkOutput("t4.alias_lo", rdata[0], 32'h5A5A_5A5A);
    idle();
    idle();

    // Reset while a read is in flight.
    wr(32'h200, 32'hCAFE_F00D, 4'b1111);
    idle();
    rd(32'h200);
    applyStimulus(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0);
    checkOutput("t5.rdata", rdata[2], 32'h0);
    checkOutput("t5.pend", {31'b0, pend[2]}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle();
      checkOutput("t5.no_rvalid", {31'b0, rvalid[2]}, 32'h0);
    end
    rd(32'h200);
    idle();
    idle();
    checkOutput("t5.retained_v", {31'b0, rvalid[2]}, 32'h1);
    checkOutput("t5.retained", rdata[2], 32'hCAFE_F00D);

    // A write between two reads of the same word.
    wr(32'h20, 32'h1, 4'b1111);
    rd(32'h20);
    wr(32'h20, 32'h2, 4'b1111);
    checkOutput("t6.first", rdata[1], 32'h1);
    rd(32'h20);
    idle();
    checkOutput("t6.second", rdata[1], 32'h2);
    idle();
    idle();

    // Random traffic over a small word pool, with aliased address bits.
    for (int i = 0; i < 20; i++) begin
      idx = (i < 16) ? i : 16383 - (i - 16);
      wr({16'($urandom), 14'(idx), 2'b00}, $urandom, 4'b1111);
    end
    for (int n = 0; n < 2000; n++) begin
      p   = $urandom_range(0, 19);
      idx = (p < 16) ? p : 16383 - (p - 16);
      a   = {16'($urandom), 14'(idx), 2'($urandom)};
      op  = $urandom_range(0, 99);
      if (op < 2)       applyStimulus(1'b1, 1'($urandom), 4'($urandom), a, $urandom);
      else if (op < 47) rd(a);
      else if (op < 77) wr(a, $urandom, 4'($urandom));
      else              idle();
    end
    for (int i = 0; i < 4; i++) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
